// File: rtl/dds_freq_meter.sv
// dds_freq_meter: recovers the DDS tuning word from the square wave it produces.
// The meter counts rising edges of signal_in[WIDTH-1] over a gate of 2^GATE_BITS clocks.
// It then scales that count by 2^(WIDTH-GATE_BITS) to give an adder estimate.
//
// Optional build macro:
//   DDS_FREQ_METER_SYNC_EN - signal_in[WIDTH-1] passes a 2-FF synchroniser before edge
//                            detection, for asynchronous sources (+2 clk latency).
//
// Ports:
//   clk         system clock, all logic on posedge
//   reset       synchronous active-low reset
//   run         1 = measure continuously, 0 = idle / abort current window
//   signal_in   DDS phase or meander word; only the MSB is used
//   edge_count  rising edges counted in the last completed gate
//   adder_est   edge_count << (WIDTH-GATE_BITS)
//   valid       one-cycle pulse when edge_count/adder_est update
//   busy        high while a gate window is in progress
module dds_freq_meter #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned GATE_BITS = 20
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run,
   input  logic [WIDTH-1:0]     signal_in,
   output logic [GATE_BITS-1:0] edge_count,
   output logic [WIDTH-1:0]     adder_est,
   output logic                 valid,
   output logic                 busy
);

   typedef enum logic [0:0] {StIdle, StGate} state_e;

   state_e                 state_q, state_d;
   logic [GATE_BITS-1:0]   gate_cnt_q, gate_cnt_d;
   logic [GATE_BITS-1:0]   edge_cnt_q, edge_cnt_d;
   logic [GATE_BITS-1:0]   edge_count_q, edge_count_d;
   logic [WIDTH-1:0]       adder_est_q, adder_est_d;
   logic                   valid_q, valid_d;
   logic                   msb_s;
   logic                   msb_q;
   logic                   rise;
   logic                   gate_done;
   logic [GATE_BITS-1:0]   edge_total;

   // Only the MSB carries frequency information.
   logic unused_signal_bits;
   assign unused_signal_bits = ^signal_in[WIDTH-2:0];

`ifdef DDS_FREQ_METER_SYNC_EN
   logic sync1_q, sync2_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= signal_in[WIDTH-1];
         sync2_q <= sync1_q;
      end
   end

   assign msb_s = sync2_q;
`else
   assign msb_s = signal_in[WIDTH-1];
`endif

   assign rise       = msb_s & ~msb_q;
   assign gate_done  = &gate_cnt_q;
   // Includes the edge seen on the terminal cycle so no edge is lost between windows.
   assign edge_total = edge_cnt_q + GATE_BITS'(rise);

   always_comb begin
      state_d      = state_q;
      gate_cnt_d   = gate_cnt_q;
      edge_cnt_d   = edge_cnt_q;
      edge_count_d = edge_count_q;
      adder_est_d  = adder_est_q;
      valid_d      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (run) begin
               state_d    = StGate;
               gate_cnt_d = '0;
               edge_cnt_d = '0;
            end
         end
         StGate: begin
            if (gate_done) begin
               edge_count_d = edge_total;
               adder_est_d  = WIDTH'(edge_total) << (WIDTH - GATE_BITS);
               valid_d      = 1'b1;
               gate_cnt_d   = '0;
               edge_cnt_d   = '0;
               if (!run) state_d = StIdle;
            end else if (!run) begin
               // Abort: partial count is simply dropped, outputs keep the last result.
               state_d = StIdle;
            end else begin
               gate_cnt_d = gate_cnt_q + 1'b1;
               edge_cnt_d = edge_total;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= StIdle;
         gate_cnt_q   <= '0;
         edge_cnt_q   <= '0;
         edge_count_q <= '0;
         adder_est_q  <= '0;
         valid_q      <= 1'b0;
         msb_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         gate_cnt_q   <= gate_cnt_d;
         edge_cnt_q   <= edge_cnt_d;
         edge_count_q <= edge_count_d;
         adder_est_q  <= adder_est_d;
         valid_q      <= valid_d;
         msb_q        <= msb_s;
      end
   end

   assign edge_count = edge_count_q;
   assign adder_est  = adder_est_q;
   assign valid      = valid_q;
   assign busy       = (state_q == StGate);

endmodule

// File: tb/tb_dds_freq_meter.sv
// Bench for dds_freq_meter with a short gate (GATE_BITS=8, 256 clocks) to keep runs brief.
// A stimulus process drives signal_in as a constant, a square wave, or a DDS phase
// accumulator. Periodic stimuli repeat a whole number of times per 256-clock window,
// so each full window has an exact, phase-independent edge count.
module tb_dds_freq_meter;

   localparam int unsigned W = 32;
   localparam int unsigned G = 8;
   localparam int unsigned WIN = 1 << G;

   logic           clk = 1'b0;
   logic           reset;
   logic           run;
   logic [W-1:0]   signal_in = '0;
   logic [G-1:0]   edge_count;
   logic [W-1:0]   adder_est;
   logic           valid;
   logic           busy;

   int tests = 0;
   int fails = 0;

   // 0 = constant MSB (param bit 0), 1 = square with half-period param, 2 = DDS adder param
   int            gen_mode  = 1;
   int unsigned   gen_param = 1;
   int unsigned   gen_cyc   = 0;
   logic [W-1:0]  gen_acc   = '0;

   dds_freq_meter #(
      .WIDTH     (W),
      .GATE_BITS (G)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .signal_in  (signal_in),
      .edge_count (edge_count),
      .adder_est  (adder_est),
      .valid      (valid),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (gen_mode)
            0: signal_in = gen_param[0] ? 32'h8000_0000 : 32'h0;
            1: begin
               gen_cyc++;
               signal_in = ((gen_cyc / gen_param) % 2 == 1) ? 32'h8000_0000 : 32'h0;
            end
            default: begin
               gen_acc   = gen_acc + gen_param;
               signal_in = gen_acc;
            end
         endcase
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Counts posedges until valid is seen at a negedge; bounded.
   task automatic wait_valid(input string name, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (valid !== 1'b1 && n < 1000);
      if (valid !== 1'b1) begin
         tests++;
         fails++;
         $display("FAIL %s: no valid within %0d clocks", name, n);
      end
   endtask

   typedef struct {
      int           mode;
      int unsigned  param;
      int unsigned  exp_cnt;
      logic [W-1:0] exp_adder;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int n;
      int vseen;
      int changed;

      vecs[0] = '{0, 0,   0,   32'h0000_0000};
      vecs[1] = '{0, 1,   0,   32'h0000_0000};
      vecs[2] = '{1, 1,   128, 32'h8000_0000};
      vecs[3] = '{1, 2,   64,  32'h4000_0000};
      vecs[4] = '{1, 4,   32,  32'h2000_0000};
      vecs[5] = '{1, 128, 1,   32'h0100_0000};
      vecs[6] = '{2, 32'h0300_0000, 3,  32'h0300_0000};
      vecs[7] = '{2, 32'h1000_0000, 16, 32'h1000_0000};

      // Reset held with run=1 and a toggling input.
      reset = 1'b0;
      run   = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset edge_count", 64'(edge_count), 64'(0));
      chk("reset adder_est", 64'(adder_est), 64'(0));
      chk("reset valid", 64'(valid), 64'(0));
      chk("reset busy", 64'(busy), 64'(0));
      reset = 1'b1;

      // First window after release: busy next clock, valid WIN+1 clocks after release.
      @(negedge clk);
      chk("busy after release", 64'(busy), 64'(1));
      wait_valid("first window", n);
      chk("first window latency", 64'(n), 64'(WIN));
      chk("first window count", 64'(edge_count), 64'(128));
      @(negedge clk);
      chk("valid pulse width", 64'(valid), 64'(0));

      for (int i = 0; i < 8; i++) begin
         gen_mode  = vecs[i].mode;
         gen_param = vecs[i].param;
         wait_valid("settle", n);
         wait_valid("settle", n);
         wait_valid("vector", n);
         chk($sformatf("vec%0d period", i), 64'(n), 64'(WIN));
         chk($sformatf("vec%0d edge_count", i), 64'(edge_count), 64'(vecs[i].exp_cnt));
         chk($sformatf("vec%0d adder_est", i), 64'(adder_est), 64'(vecs[i].exp_adder));
      end

      // Abort mid-window at gate_cnt=100; last result (16) must hold, no valid.
      repeat (100) @(negedge clk);
      run = 1'b0;
      @(negedge clk);
      chk("abort busy", 64'(busy), 64'(0));
      gen_mode  = 1;
      gen_param = 2;
      vseen   = 0;
      changed = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (valid !== 1'b0) vseen++;
         if (edge_count !== 8'd16 || adder_est !== 32'h1000_0000) changed++;
      end
      chk("abort no valid", 64'(vseen), 64'(0));
      chk("abort outputs held", 64'(changed), 64'(0));
      chk("abort edge_count", 64'(edge_count), 64'(16));
      run = 1'b1;
      wait_valid("restart", n);
      chk("restart latency", 64'(n), 64'(WIN + 1));
      chk("restart edge_count", 64'(edge_count), 64'(64));
      chk("restart adder_est", 64'(adder_est), 64'(32'h4000_0000));

      // Reset mid-window after a prior result.
      repeat (50) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("midreset edge_count", 64'(edge_count), 64'(0));
      chk("midreset adder_est", 64'(adder_est), 64'(0));
      chk("midreset valid", 64'(valid), 64'(0));
      chk("midreset busy", 64'(busy), 64'(0));
      reset = 1'b1;
      wait_valid("post reset", n);
      chk("post reset latency", 64'(n), 64'(WIN + 1));
      chk("post reset edge_count", 64'(edge_count), 64'(64));
      chk("post reset busy", 64'(busy), 64'(1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
